// File: rtl/lpc_reg_bank_v2_pkg.sv
// Shared LPC register-bank definitions: default widths, per-bit access types,
// the board ID constant and slice/precedence helpers.
package lpc_pkg;

  localparam int LPC_DW = 8;
  localparam int LPC_AW = 8;

  // Identification byte intended for register 0 of the board register map.
  localparam logic [LPC_DW-1:0] LPC_FPGA_ID = 8'hA5;

  typedef enum logic [1:0] {
    RO,
    RW,
    HW,
    W1C
  } lpc_bit_type_e;

  function automatic int reg_slice(input int i, input int dw = LPC_DW);
    return i * dw;
  endfunction

  // Sticky events outrank hardware tracking, which outranks software access.
  function automatic lpc_bit_type_e bit_type(input logic sw, input logic hw, input logic w1c);
    if (w1c) return W1C;
    if (hw) return HW;
    if (sw) return RW;
    return RO;
  endfunction

endpackage

// File: rtl/lpc_reg_bank_v2_sync2.sv
// Two-flop synchroniser for asynchronous status pins, cleared to 0 on reset.
module lpc_sync2 #(
  parameter int W = 1
) (
  input  logic         LpcClock,
  input  logic         PciReset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/lpc_reg_bank_v2.sv
// Parametrised LPC register bank: per-bit RO/RW/HW/W1C access selected by
// elaboration-time masks, synchronised status inputs and a sticky-event IRQ.
module lpc_reg_bank_v2
  import lpc_pkg::*;
#(
  parameter int                       NUM_REGS    = 32,
  parameter int                       DW          = LPC_DW,
  parameter int                       AW          = LPC_AW,
  parameter logic [NUM_REGS*DW-1:0]   RESET_VAL   = '0,
  parameter logic [NUM_REGS*DW-1:0]   SW_MASK     = '1,
  parameter logic [NUM_REGS*DW-1:0]   HW_MASK     = '0,
  parameter logic [NUM_REGS*DW-1:0]   W1C_MASK    = '0,
  parameter int                       IRQ_EN_ADDR = 'h1F
) (
  input  logic                   PciReset,
  input  logic                   LpcClock,
  input  logic [AW-1:0]          Addr,
  input  logic                   Wr,
  input  logic                   Rd,
  input  logic [DW-1:0]          DataWrSW,
  input  logic [NUM_REGS*DW-1:0] HwIn,
  output logic [DW-1:0]          RdData,
  output logic                   RdValid,
  output logic [NUM_REGS*DW-1:0] DataReg,
  output logic                   Irq
);

  localparam int TW = NUM_REGS * DW;

  logic [TW-1:0]       hw_sync;
  logic [TW-1:0]       hist;
  logic [TW-1:0]       rise;
  logic [TW-1:0]       data_q;
  logic [NUM_REGS-1:0] wr_hit;
  logic [1:0]          arm_cnt;
  logic                armed;
  logic [DW-1:0]       rd_mux;

  lpc_sync2 #(.W(TW)) u_sync (
    .LpcClock (LpcClock),
    .PciReset (PciReset),
    .d        (HwIn),
    .q        (hw_sync)
  );

  // The arm delay lets the edge history catch up with the synchroniser after
  // reset, so a pin already high at reset release never looks like an event.
  assign armed = (arm_cnt == 2'd3);

  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      arm_cnt <= 2'd0;
      hist    <= '0;
    end else begin
      if (!armed) arm_cnt <= arm_cnt + 2'd1;
      hist <= hw_sync;
    end
  end

  assign rise = hw_sync & ~hist & {TW{armed}};

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    assign wr_hit[r] = Wr && (Addr == AW'(r));

    for (genvar b = 0; b < DW; b++) begin : g_bit
      localparam int            IDX = reg_slice(r, DW) + b;
      localparam lpc_bit_type_e BT  = bit_type(SW_MASK[IDX], HW_MASK[IDX], W1C_MASK[IDX]);

      logic nxt;

      always_comb begin
        nxt = data_q[IDX];
        case (BT)
          // A hardware set in the same cycle as a clear keeps the bit at 1.
          W1C:     nxt = rise[IDX] | (data_q[IDX] & ~(wr_hit[r] & DataWrSW[b]));
          HW:      nxt = hw_sync[IDX];
          RW:      if (wr_hit[r]) nxt = DataWrSW[b];
          default: nxt = RESET_VAL[IDX];
        endcase
      end

      always_ff @(posedge LpcClock or negedge PciReset) begin
        if (!PciReset) data_q[IDX] <= RESET_VAL[IDX];
        else           data_q[IDX] <= nxt;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (Addr == AW'(i)) rd_mux = data_q[i*DW +: DW];
    end
  end

  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      RdData  <= '0;
      RdValid <= 1'b0;
    end else begin
      RdValid <= Rd;
      if (Rd) RdData <= rd_mux;
    end
  end

  if (IRQ_EN_ADDR < NUM_REGS) begin : g_irq
    logic irq_q;

    always_ff @(posedge LpcClock or negedge PciReset) begin
      if (!PciReset) irq_q <= 1'b0;
      else           irq_q <= data_q[reg_slice(IRQ_EN_ADDR, DW)] & (|(data_q & W1C_MASK));
    end

    assign Irq = irq_q;
  end else begin : g_no_irq
    assign Irq = 1'b0;
  end

  assign DataReg = data_q;

endmodule
